// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with one write port, one read port, per-byte write enables and a
// read-during-write policy. Also provides a read-valid pipeline and a clear sequencer.
module ram_dp_be #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  collision,
  input  logic                  clr,
  output logic                  busy
);
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_hit, rd_hit, wr_ok, rd_ok, same;
  logic [DATA_WIDTH-1:0] rd_old, rd_fwd, rd_word;

  assign wr_hit = {1'b0, wr_addr} < DEPTH_W;
  assign rd_hit = {1'b0, rd_addr} < DEPTH_W;
  assign wr_ok  = wren & ~busy & wr_hit;
  assign rd_ok  = rden & ~busy;
  // Only a write that actually lands in the array counts as a collision.
  assign same   = wr_ok & rd_hit & (wr_addr == rd_addr);

  assign rd_old = rd_hit ? mem[rd_addr] : '0;

  for (genvar gb = 0; gb < BE_WIDTH; gb++) begin : g_fwd
    assign rd_fwd[8*gb +: 8] = (same && wr_be[gb]) ? wr_data[8*gb +: 8] : rd_old[8*gb +: 8];
  end

  assign rd_word = (RDW_MODE != 0) ? rd_fwd : rd_old;

  // Array has no reset: contents survive rst_n, and an aborted clear leaves the tail intact.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < BE_WIDTH; b++)
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (clr) begin
          state   <= CLEAR;
          busy    <= 1'b1;
          clr_cnt <= '0;
        end
        CLEAR: if (clr_cnt == LAST) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          clr_cnt <= clr_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [STAGES:1]       vld_pipe, col_pipe;
  logic [DATA_WIDTH-1:0] d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      col_pipe <= '0;
      d1       <= '0;
    end else begin
      vld_pipe[1] <= rd_ok;
      col_pipe[1] <= rd_ok & same;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        col_pipe[s] <= col_pipe[s-1];
      end
      if (rd_ok) d1 <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] d2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           d2 <= '0;
      else if (vld_pipe[1]) d2 <= d1;
    end
    assign q = d2;
  end else begin : g_noreg
    assign q = d1;
  end

  assign q_valid   = vld_pipe[STAGES];
  assign collision = col_pipe[STAGES];
endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two instances (8-bit/256/old-data/latency 1 and
// 32-bit/200/new-data/latency 2) share stimulus and are checked against an array model.
module tb_ram_dp_be;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wren = 1'b0, rden = 1'b0, clr = 1'b0;
  logic [7:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic [7:0]  q0;
  logic [31:0] q1;
  logic        qv0, qv1, col0, col1, busy0, busy1;

  always #5 clk = ~clk;

  ram_dp_be #(.DATA_WIDTH(8), .DEPTH(256), .ADDR_WIDTH(8), .RDW_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
    .wr_be(wr_be[0:0]), .rden(rden), .rd_addr(rd_addr), .q(q0), .q_valid(qv0),
    .collision(col0), .clr(clr), .busy(busy0));

  ram_dp_be #(.DATA_WIDTH(32), .DEPTH(200), .ADDR_WIDTH(8), .RDW_MODE(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rden(rden), .rd_addr(rd_addr), .q(q1), .q_valid(qv1),
    .collision(col1), .clr(clr), .busy(busy1));

  localparam int DEP   [2] = '{256, 200};
  localparam int LAT   [2] = '{1, 2};
  localparam int RDW   [2] = '{0, 1};
  localparam int BYTES [2] = '{1, 4};

  typedef struct packed {logic [31:0] d; logic c;} res_t;

  logic [31:0] mm [2][256];
  int          left_m [2];
  int          idx_m  [2];
  logic [31:0] eq [2];
  logic        ev [2], ec [2], eb [2];
  res_t        sched [int];   // key = completion_edge*2 + instance
  int          ecnt = 0;
  int          checks = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, got, exp, ecnt);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be, input int nb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < nb; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Apply the current inputs to the model as if the next rising edge samples them.
  task automatic model_step();
    logic [31:0] old, dv;
    logic        c;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) continue;
      if (left_m[d] > 0) begin
        mm[d][idx_m[d]] = '0;
        idx_m[d]++;
        left_m[d]--;
        continue;
      end
      if (rden) begin
        old = (int'(rd_addr) < DEP[d]) ? mm[d][rd_addr] : '0;
        c   = wren && (wr_addr == rd_addr) && (int'(rd_addr) < DEP[d]);
        dv  = (c && RDW[d] == 1) ? merge(old, wr_data, wr_be, BYTES[d]) : old;
        sched[(ecnt + LAT[d]) * 2 + d] = '{d: dv, c: c};
      end
      if (wren && int'(wr_addr) < DEP[d])
        mm[d][wr_addr] = merge(mm[d][wr_addr], wr_data, wr_be, BYTES[d]);
      if (clr) begin
        left_m[d] = DEP[d];
        idx_m[d]  = 0;
      end
    end
  endtask

  task automatic cyc();
    int k;
    model_step();
    @(posedge clk);
    ecnt++;
    for (int d = 0; d < 2; d++) begin
      k = ecnt * 2 + d;
      if (sched.exists(k)) begin
        eq[d] = sched[k].d;
        ev[d] = 1'b1;
        ec[d] = sched[k].c;
        sched.delete(k);
      end else begin
        ev[d] = 1'b0;
        ec[d] = 1'b0;
      end
      eb[d] = left_m[d] > 0;
    end
    #2;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      eq[d] = '0; ev[d] = 1'b0; ec[d] = 1'b0; eb[d] = 1'b0; left_m[d] = 0;
    end
    sched.delete();
  endtask

  task automatic idle();
    wren = 1'b0; rden = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] dt, input logic [3:0] be);
    wren = 1'b1; wr_addr = a; wr_data = dt; wr_be = be; rden = 1'b0;
    cyc();
    wren = 1'b0;
  endtask

  function automatic logic [7:0] raddr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(190, 255));
    return 8'($urandom_range(0, 15));
  endfunction

  always @(negedge clk) begin
    chk("q0", {24'h0, q0}, {24'h0, eq[0][7:0]});
    chk("q_valid0", {31'h0, qv0}, {31'h0, ev[0]});
    chk("collision0", {31'h0, col0}, {31'h0, ec[0]});
    chk("busy0", {31'h0, busy0}, {31'h0, eb[0]});
    chk("q1", q1, eq[1]);
    chk("q_valid1", {31'h0, qv1}, {31'h0, ev[1]});
    chk("collision1", {31'h0, col1}, {31'h0, ec[1]});
    chk("busy1", {31'h0, busy1}, {31'h0, eb[1]});
  end

  initial begin
    int n0, n1;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++) mm[d][a] = '0;  // defined by the initial clear below
    idx_m[0] = 0; idx_m[1] = 0;
    model_reset();
    #1 rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    chk("reset_busy0", {31'h0, busy0}, 32'h0);
    chk("reset_q1", q1, 32'h0);

    // Initial clear; both busy windows counted.
    clr = 1'b1; n0 = 0; n1 = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(); clr = 1'b0;
      if (busy0) n0++;
      if (busy1) n1++;
    end
    chk("clr_len_256", n0, 256);
    chk("clr_len_200", n1, 200);

    // Basic write then read.
    wr(8'h10, 32'h000000A5, 4'hF);
    rden = 1'b1; rd_addr = 8'h10; cyc(); rden = 1'b0;
    chk("rd_a5_q", {24'h0, q0}, 32'hA5);
    chk("rd_a5_v", {31'h0, qv0}, 32'h1);
    cyc();
    chk("rd_a5_q1", q1, 32'hA5);
    wr(8'hFF, 32'h0000003C, 4'hF);
    rden = 1'b1; rd_addr = 8'hFF; cyc(); rden = 1'b0;
    chk("rd_3c_q", {24'h0, q0}, 32'h3C);
    cyc();
    chk("rd_oor_q1", q1, 32'h0);
    chk("rd_oor_v1", {31'h0, qv1}, 32'h1);

    // Byte enables.
    wr(8'd5, 32'h11223344, 4'hF);
    wr(8'd5, 32'hAABBCCDD, 4'b0101);
    rden = 1'b1; rd_addr = 8'd5; cyc(); rden = 1'b0;
    chk("be_q0", {24'h0, q0}, 32'hDD);
    cyc();
    chk("be_q1", q1, 32'h11BB33DD);

    // Same-address read during write at 7.
    wren = 1'b1; wr_addr = 8'd7; wr_data = 32'h0000005A; wr_be = 4'hF;
    rden = 1'b1; rd_addr = 8'd7;
    cyc(); idle();
    chk("rdw_old_q0", {24'h0, q0}, 32'h0);
    chk("rdw_col0", {31'h0, col0}, 32'h1);
    cyc();
    chk("rdw_new_q1", q1, 32'h5A);
    chk("rdw_col1", {31'h0, col1}, 32'h1);

    // Back-to-back reads with output register.
    wr(8'd1, 32'hC0DE0001, 4'hF);
    wr(8'd2, 32'hC0DE0002, 4'hF);
    wr(8'd3, 32'hC0DE0003, 4'hF);
    rden = 1'b1; rd_addr = 8'd1; cyc();
    chk("b2b_v_e0", {31'h0, qv1}, 32'h0);
    rd_addr = 8'd2; cyc();
    chk("b2b_q_1", q1, 32'hC0DE0001);
    rd_addr = 8'd3; cyc(); rden = 1'b0;
    chk("b2b_q_2", q1, 32'hC0DE0002);
    cyc();
    chk("b2b_q_3", q1, 32'hC0DE0003);
    chk("b2b_v_3", {31'h0, qv1}, 32'h1);
    cyc();
    chk("b2b_v_end", {31'h0, qv1}, 32'h0);

    // Random traffic including occasional clears.
    for (int i = 0; i < 400; i++) begin
      wren = 1'($urandom); wr_addr = raddr(); wr_data = $urandom; wr_be = 4'($urandom);
      rden = 1'($urandom);
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : raddr();
      clr = ($urandom_range(0, 99) == 0);
      cyc();
    end
    idle();
    repeat (260) cyc();

    // Fill every word with nonzero data, then clear with traffic during busy.
    for (int i = 0; i < 256; i++) wr(8'(i), {4{8'(i) | 8'h01}}, 4'hF);
    clr = 1'b1; n0 = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(); clr = 1'b0;
      if (busy0) begin
        n0++;
        wren = 1'($urandom); wr_addr = 8'($urandom); wr_data = $urandom | 32'h1;
        wr_be = 4'hF; rden = 1'($urandom); rd_addr = 8'($urandom);
      end else begin
        wren = 1'b0; rden = 1'b0;
      end
    end
    chk("clr2_len_256", n0, 256);
    for (int i = 0; i < 256; i++) begin
      rden = 1'b1; rd_addr = 8'(i); cyc();
      chk("after_clr_q0", {24'h0, q0}, 32'h0);
    end
    idle(); cyc(); cyc();

    // Reset 100 cycles into a clear.
    wr(8'd200, 32'h77777777, 4'hF);
    wr(8'd150, 32'h99999999, 4'hF);
    clr = 1'b1; cyc(); clr = 1'b0;
    repeat (100) cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy0", {31'h0, busy0}, 32'h0);
    chk("abort_q0", {24'h0, q0}, 32'h0);
    chk("abort_busy1", {31'h0, busy1}, 32'h0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rden = 1'b1; rd_addr = 8'(i); cyc();
      chk("abort_zero_q0", {24'h0, q0}, 32'h0);
    end
    rd_addr = 8'd200; cyc();
    chk("abort_keep200", {24'h0, q0}, 32'h77);
    rd_addr = 8'd150; cyc(); rden = 1'b0;
    chk("abort_keep150", {24'h0, q0}, 32'h99);
    cyc();
    chk("abort_keep150_q1", q1, 32'h99999999);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
